// File: rtl/lsu_pkg.sv
// Load/store unit shared types: FSM states, access sizes, decoded op struct,
// ALU operation codes for memory ops, and lane/alignment helper functions.
package lsu_pkg;

  localparam int unsigned OP_WIDTH   = 8;
  localparam int unsigned RD_WIDTH   = 5;
  localparam int unsigned WORD_WIDTH = 32;
  localparam int unsigned STRB_WIDTH = 4;

  // Memory-op codes as emitted by the decode-stage ALU-operation generator.
  localparam logic [OP_WIDTH-1:0] ALU_OPERATIONS_LB  = 8'h20;
  localparam logic [OP_WIDTH-1:0] ALU_OPERATIONS_LH  = 8'h21;
  localparam logic [OP_WIDTH-1:0] ALU_OPERATIONS_LW  = 8'h22;
  localparam logic [OP_WIDTH-1:0] ALU_OPERATIONS_LBU = 8'h23;
  localparam logic [OP_WIDTH-1:0] ALU_OPERATIONS_LHU = 8'h24;
  localparam logic [OP_WIDTH-1:0] ALU_OPERATIONS_SB  = 8'h25;
  localparam logic [OP_WIDTH-1:0] ALU_OPERATIONS_SH  = 8'h26;
  localparam logic [OP_WIDTH-1:0] ALU_OPERATIONS_SW  = 8'h27;

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} lsu_state_t;
  typedef enum logic [1:0] {BYTE, HALF, WORD} lsu_size_t;

  typedef struct packed {
    logic      is_load;
    logic      is_store;
    lsu_size_t size;
    logic      is_unsigned;
  } lsu_op_t;

  // Decode an ALU operation code; non-memory codes yield all-zero flags.
  function automatic lsu_op_t lsu_decode(input logic [OP_WIDTH-1:0] code);
    lsu_op_t op;
    op = '0;
    case (code)
      ALU_OPERATIONS_LB:  begin op.is_load = 1'b1; op.size = BYTE; end
      ALU_OPERATIONS_LH:  begin op.is_load = 1'b1; op.size = HALF; end
      ALU_OPERATIONS_LW:  begin op.is_load = 1'b1; op.size = WORD; end
      ALU_OPERATIONS_LBU: begin op.is_load = 1'b1; op.size = BYTE; op.is_unsigned = 1'b1; end
      ALU_OPERATIONS_LHU: begin op.is_load = 1'b1; op.size = HALF; op.is_unsigned = 1'b1; end
      ALU_OPERATIONS_SB:  begin op.is_store = 1'b1; op.size = BYTE; end
      ALU_OPERATIONS_SH:  begin op.is_store = 1'b1; op.size = HALF; end
      ALU_OPERATIONS_SW:  begin op.is_store = 1'b1; op.size = WORD; end
      default: ;
    endcase
    return op;
  endfunction

  function automatic logic lsu_aligned(input lsu_size_t size, input logic [1:0] off);
    case (size)
      HALF:    return ~off[0];
      WORD:    return (off == 2'b00);
      default: return 1'b1;
    endcase
  endfunction

  function automatic logic [STRB_WIDTH-1:0] lsu_wstrb(input lsu_size_t size, input logic [1:0] off);
    case (size)
      BYTE:    return 4'b0001 << off;
      HALF:    return off[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Replicate the store operand across every lane it could land in.
  function automatic logic [WORD_WIDTH-1:0] lsu_wdata(input lsu_size_t size, input logic [WORD_WIDTH-1:0] d);
    case (size)
      BYTE:    return {4{d[7:0]}};
      HALF:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory port: single-outstanding req/gnt/rvalid handshake.
// master = load/store unit side, slave = memory side.
interface load_store_unit_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic                  mem_req;
  logic                  mem_gnt;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [STRB_WIDTH-1:0] mem_wstrb;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  mem_rvalid;
  logic [DATA_WIDTH-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/load_store_unit_load_aligner.sv
// Combinational load extraction: picks the addressed byte/half from the read
// word and sign- or zero-extends it; words pass through.
// Ports: rdata (read word), offset (address[1:0]), size, is_unsigned -> result_c.
module load_aligner
  import lsu_pkg::*;
(
  input  logic [WORD_WIDTH-1:0] rdata,
  input  logic [1:0]            offset,
  input  lsu_size_t             size,
  input  logic                  is_unsigned,
  output logic [WORD_WIDTH-1:0] result_c
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      BYTE:    result_c = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
      HALF:    result_c = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
      default: result_c = rdata;
    endcase
  end
endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit. Accepts one op in IDLE, checks alignment,
// drives a single-outstanding request to data memory and returns an extended,
// rd-tagged load result (or a bare completion pulse for stores).
// Ports: clk/rst; upstream req_valid/req_ready, alu_operation, address,
// store_data, rd_in, flush; response resp_valid, load_data, rd_out,
// misaligned_fault; mem (data-memory master port).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [OP_WIDTH-1:0]   alu_operation,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [RD_WIDTH-1:0]   rd_in,
  input  logic                  flush,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic [RD_WIDTH-1:0]   rd_out,
  output logic                  misaligned_fault,
  load_store_unit_if.master     mem
);
  lsu_state_t state, state_n;
  logic       kill_q, kill_n;
  logic       store_q;
  lsu_size_t  size_q;
  logic       uns_q;
  logic [1:0] off_q;
  logic [RD_WIDTH-1:0] rd_q;

  lsu_op_t    op_in;
  logic       aligned_c;
  logic       accept;
  logic       fault_n, resp_n;
  logic [DATA_WIDTH-1:0] load_n;
  logic [RD_WIDTH-1:0]   rd_n;
  logic [WORD_WIDTH-1:0] extracted_c;

  assign op_in     = lsu_decode(alu_operation);
  assign aligned_c = lsu_aligned(op_in.size, address[1:0]);

  load_aligner u_load_aligner (
    .rdata       (mem.mem_rdata),
    .offset      (off_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .result_c    (extracted_c)
  );

  // Next-state and response decisions.
  always_comb begin
    state_n = state;
    kill_n  = kill_q;
    accept  = 1'b0;
    fault_n = 1'b0;
    resp_n  = 1'b0;
    load_n  = '0;
    rd_n    = '0;
    case (state)
      IDLE: begin
        if (req_valid && (op_in.is_load || op_in.is_store)) begin
          if (aligned_c) begin
            accept  = 1'b1;
            kill_n  = 1'b0;
            state_n = REQ;
          end else begin
            fault_n = 1'b1;
          end
        end
      end
      REQ: begin
        // A flush coinciding with the grant is deferred into WAIT_R.
        if (mem.mem_gnt) begin
          if (store_q) begin
            state_n = IDLE;
            resp_n  = 1'b1;
          end else begin
            state_n = WAIT_R;
            kill_n  = flush;
          end
        end else if (flush) begin
          state_n = IDLE;
        end
      end
      WAIT_R: begin
        if (flush) kill_n = 1'b1;
        if (mem.mem_rvalid) begin
          state_n = IDLE;
          if (!(kill_q || flush)) begin
            resp_n = 1'b1;
            load_n = DATA_WIDTH'(extracted_c);
            rd_n   = rd_q;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      kill_q           <= 1'b0;
      store_q          <= 1'b0;
      size_q           <= BYTE;
      uns_q            <= 1'b0;
      off_q            <= 2'b00;
      rd_q             <= '0;
      req_ready        <= 1'b1;
      resp_valid       <= 1'b0;
      misaligned_fault <= 1'b0;
      load_data        <= '0;
      rd_out           <= '0;
      mem.mem_req      <= 1'b0;
      mem.mem_we       <= 1'b0;
      mem.mem_addr     <= '0;
      mem.mem_wstrb    <= '0;
      mem.mem_wdata    <= '0;
    end else begin
      state            <= state_n;
      kill_q           <= kill_n;
      req_ready        <= (state_n == IDLE);
      resp_valid       <= resp_n;
      misaligned_fault <= fault_n;
      load_data        <= load_n;
      rd_out           <= rd_n;
      mem.mem_req      <= (state_n == REQ);
      if (accept) begin
        store_q       <= op_in.is_store;
        size_q        <= op_in.size;
        uns_q         <= op_in.is_unsigned;
        off_q         <= address[1:0];
        rd_q          <= rd_in;
        mem.mem_we    <= op_in.is_store;
        mem.mem_addr  <= {address[ADDR_WIDTH-1:2], 2'b00};
        mem.mem_wstrb <= op_in.is_store ? lsu_wstrb(op_in.size, address[1:0]) : '0;
        mem.mem_wdata <= op_in.is_store ? DATA_WIDTH'(lsu_wdata(op_in.size, WORD_WIDTH'(store_data))) : '0;
      end else if (state_n != REQ) begin
        mem.mem_we    <= 1'b0;
        mem.mem_wstrb <= '0;
        mem.mem_wdata <= '0;
      end
    end
  end
endmodule
